inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Fetch sequencer that owns the instruction memory port.
- Holds the program counter and drives the memory chip-enable and address; the memory returns read data combinationally in the same cycle.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts jump redirects from execute, which flush the FIFO and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
FIFO_DEPTH, 2, number of buffered {pc, inst} entries; power of two, 2..8.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-low; the block resets while rst==0.
run  in  1  fetch enable from the core control.
rom_ce  out  1  instruction memory enable; 1 = enabled, 0 = disabled (`RomDisable).
rom_addr  out  32  byte address to instruction memory; always equals the PC register.
rom_data  in  32  instruction word from memory, valid in the same cycle that rom_ce==1.
jump_valid  in  1  single-cycle redirect request.
jump_addr  in  32  redirect target byte address.
inst_valid  out  1  head FIFO entry is available to decode.
inst_ready  in  1  decode accepts the head entry.
inst_out  out  32  head instruction word; `Zero when the FIFO is empty.
inst_pc  out  32  PC of the head instruction; `Zero when the FIFO is empty.
misalign  out  1  sticky flag: a jump target had addr[1:0]!=0.
fifo_count  out  4  current number of FIFO entries.

Behaviour:
- Reset (rst==0, asynchronous): pc=RESET_PC, FIFO empty, state=IDLE, misalign=0. Resulting outputs: rom_ce=0, inst_valid=0, inst_out=0, inst_pc=0, fifo_count=0. Reset asserted mid-operation discards all buffered entries immediately.
- States:
  - IDLE: rom_ce=0. Next state is FETCH when run==1.
  - FETCH: next state is IDLE when run==0. Buffered entries remain and continue to drain in IDLE.
- rom_ce = (state==FETCH) && (fifo_count<FIFO_DEPTH) && !jump_valid. This is purely combinational and has no path from inst_ready.
- Push: in a cycle with rom_ce==1, write {pc, rom_data} at the FIFO tail and set pc<=pc+4.
  - Addition is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Zero-latency memory model: an entry pushed at edge N is visible at the head after edge N when the FIFO was empty.
- Pop: in a cycle with inst_valid && inst_ready && !jump_valid, remove the head entry.
- Push and pop in the same cycle: fifo_count is unchanged and the FIFO pointers wrap modulo FIFO_DEPTH.
- When full (count==FIFO_DEPTH), no push occurs that cycle; a pop that cycle frees the slot for the next cycle. Steady-state throughput is 1 instruction/cycle when decode is always ready.
- Jump (jump_valid==1, any state):
  - At the next edge: FIFO flushed (count=0), pc<=jump_addr with bits [1:0] forced to 0.
  - Any handshake in that cycle is ignored and the entry is discarded; no push occurs that cycle.
  - If jump_addr[1:0]!=0, misalign<=1; it stays set until reset.
  - Fetch from the new PC begins the following cycle if state is FETCH.
- Jump and run==0 in the same cycle: flush and PC reload still occur, and state goes to IDLE.
- jump_valid in IDLE: updates pc and flushes the FIFO, with no fetch.
- run toggling does not alter the PC. Fetch resumes at the next sequential address.
- Outputs inst_out/inst_pc are taken combinationally from the head register and read `Zero when inst_valid==0.

Test Plan:
- Reset/start: memory holds 34011100 at 0x0 and 30020020 at 0x4; hold rst=0 then release with run=1 and inst_ready=1 -> rom_ce=0 during reset; decode then sees (pc 0x0, 34011100) followed by (pc 0x4, 30020020) on consecutive cycles, one instruction per cycle.
- Backpressure: inst_ready=0 for 5 cycles -> fifo_count saturates at 2 and rom_ce=0 while full, pc holds at 0x8; raise inst_ready -> entries 0x0, 0x4, 0x8 are delivered in order with no loss or duplication.
- Jump flush: with 2 entries buffered, pulse jump_valid with jump_addr=0x20 -> next cycle fifo_count=0 and rom_addr=0x20; the next delivered inst_pc is 0x20; the entry offered during the jump cycle is never accepted.
- Misaligned jump: jump_addr=0x32 -> rom_addr=0x30 and misalign=1; misalign stays 1 after later aligned jumps, until rst=0.
- Wrap and run: reset with RESET_PC=32'hFFFF_FFFC -> inst_pc sequence is FFFFFFFC then 00000000; deassert run for 3 cycles -> rom_ce=0, buffered entries drain, pc is unchanged; reassert run -> fetch resumes at the next address.
- Async reset mid-stream: assert rst=0 between clock edges while fifo_count=2 -> inst_valid=0, fifo_count=0 and rom_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-unit bus bundle: instruction memory port, jump redirect and decode handshake.
// The master modport is the fetch controller's view; slave is the environment's view.
interface inst_fetch_ctrl_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    output rom_ce,
    output rom_addr,
    input  rom_data,
    input  jump_valid,
    input  jump_addr,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc
  );

  modport slave (
    input  rom_ce,
    input  rom_addr,
    output rom_data,
    output jump_valid,
    output jump_addr,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and the zero-latency instruction memory port,
// buffers {pc, inst} pairs in a small FIFO for decode, and services jump redirects.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  inst_fetch_ctrl_if.master         bus,
  output logic                      misalign,
  output logic [3:0]                fifo_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {StIdle, StFetch} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [3:0]        count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       pc_mem_q   [FIFO_DEPTH];
  logic [31:0]       inst_mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              not_full;

  assign not_full       = (count_q < 4'(FIFO_DEPTH));
  assign bus.inst_valid = (count_q != 4'd0);
  assign bus.inst_out   = bus.inst_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc    = bus.inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign bus.rom_addr   = pc_q;
  assign misalign       = misalign_q;
  assign fifo_count     = count_q;

  // rom_ce deliberately has no path from inst_ready; a pop only frees a slot next cycle.
  assign bus.rom_ce = (state_q == StFetch) && not_full && !bus.jump_valid;
  assign push       = bus.rom_ce;
  assign pop        = bus.inst_valid && bus.inst_ready && !bus.jump_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    misalign_d = misalign_q;

    unique case (state_q)
      StIdle:  if (run)  state_d = StFetch;
      StFetch: if (!run) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bus.jump_valid) begin
      pc_d     = {bus.jump_addr[31:2], 2'b00};
      count_d  = 4'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (bus.jump_addr[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      count_q    <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage needs no reset: entries are only observable while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= bus.rom_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: one instance at RESET_PC=0 and one at the top of the
// address space to exercise PC wrap-around.
module tb_inst_fetch_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic run;
  logic misalign_a, misalign_b;
  logic [3:0] count_a, count_b;

  int n_total;
  int n_pass;
  int n_fail;

  inst_fetch_ctrl_if a_if ();
  inst_fetch_ctrl_if b_if ();

  function automatic logic [31:0] rom_f(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h3401_1100;
      32'h0000_0004: return 32'h3002_0020;
      default:       return ~addr;
    endcase
  endfunction

  assign a_if.rom_data = rom_f(a_if.rom_addr);
  assign b_if.rom_data = rom_f(b_if.rom_addr);

  inst_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .run        (run),
    .bus        (a_if.master),
    .misalign   (misalign_a),
    .fifo_count (count_a)
  );

  inst_fetch_ctrl #(
    .RESET_PC   (32'hFFFF_FFFC),
    .FIFO_DEPTH (2)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .run        (run),
    .bus        (b_if.master),
    .misalign   (misalign_b),
    .fifo_count (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    run   = 1'b1;
    a_if.jump_valid = 1'b0;
    a_if.jump_addr  = 32'h0;
    a_if.inst_ready = 1'b1;
    b_if.jump_valid = 1'b0;
    b_if.jump_addr  = 32'h0;
    b_if.inst_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_rom_ce",     {31'b0, a_if.rom_ce},     32'h0);
    chk("rst_inst_valid", {31'b0, a_if.inst_valid}, 32'h0);
    chk("rst_inst_out",   a_if.inst_out,            32'h0);
    chk("rst_inst_pc",    a_if.inst_pc,             32'h0);
    chk("rst_count",      {28'b0, count_a},         32'h0);
    chk("rst_rom_addr",   a_if.rom_addr,            32'h0);
    tick();
    tick();
    chk("rst_hold_rom_ce", {31'b0, a_if.rom_ce}, 32'h0);

    // Start: IDLE -> FETCH, then one instruction per cycle
    rst_a = 1'b1;
    tick();
    chk("start_rom_ce",   {31'b0, a_if.rom_ce},     32'h1);
    chk("start_rom_addr", a_if.rom_addr,            32'h0);
    chk("start_valid",    {31'b0, a_if.inst_valid}, 32'h0);
    tick();
    chk("first_pc",   a_if.inst_pc,  32'h0);
    chk("first_inst", a_if.inst_out, 32'h3401_1100);
    chk("first_addr", a_if.rom_addr, 32'h4);
    tick();
    chk("second_pc",    a_if.inst_pc,     32'h4);
    chk("second_inst",  a_if.inst_out,    32'h3002_0020);
    chk("second_count", {28'b0, count_a}, 32'h1);

    // Backpressure: FIFO saturates, PC holds
    a_if.inst_ready = 1'b0;
    tick();
    chk("bp_count_fill", {28'b0, count_a}, 32'h2);
    repeat (4) tick();
    chk("bp_count", {28'b0, count_a},     32'h2);
    chk("bp_rom_ce", {31'b0, a_if.rom_ce}, 32'h0);
    chk("bp_addr",  a_if.rom_addr,        32'hC);
    chk("bp_head",  a_if.inst_pc,         32'h4);
    a_if.inst_ready = 1'b1;
    tick();
    chk("drain_pc8",    a_if.inst_pc,         32'h8);
    chk("drain_inst8",  a_if.inst_out,        32'hFFFF_FFF7);
    chk("drain_count",  {28'b0, count_a},     32'h1);
    chk("drain_rom_ce", {31'b0, a_if.rom_ce}, 32'h1);
    tick();
    chk("drain_pcC",   a_if.inst_pc,  32'hC);
    chk("drain_instC", a_if.inst_out, 32'hFFFF_FFF3);

    // Jump flush with two entries buffered; offered head is dropped
    a_if.inst_ready = 1'b0;
    tick();
    chk("jf_count_pre", {28'b0, count_a}, 32'h2);
    a_if.jump_valid = 1'b1;
    a_if.jump_addr  = 32'h20;
    a_if.inst_ready = 1'b1;
    #1;
    chk("jf_rom_ce", {31'b0, a_if.rom_ce}, 32'h0);
    tick();
    a_if.jump_valid = 1'b0;
    chk("jf_count", {28'b0, count_a},     32'h0);
    chk("jf_addr",  a_if.rom_addr,        32'h20);
    chk("jf_valid", {31'b0, a_if.inst_valid}, 32'h0);
    tick();
    chk("jf_next_pc",   a_if.inst_pc,  32'h20);
    chk("jf_next_inst", a_if.inst_out, 32'hFFFF_FFDF);

    // Misaligned jump: target aligned down, sticky flag
    chk("mis_clear", {31'b0, misalign_a}, 32'h0);
    a_if.jump_valid = 1'b1;
    a_if.jump_addr  = 32'h32;
    tick();
    a_if.jump_valid = 1'b0;
    chk("mis_addr",  a_if.rom_addr,        32'h30);
    chk("mis_flag",  {31'b0, misalign_a},  32'h1);
    chk("mis_count", {28'b0, count_a},     32'h0);
    tick();
    chk("mis_next_pc", a_if.inst_pc, 32'h30);
    a_if.jump_valid = 1'b1;
    a_if.jump_addr  = 32'h40;
    tick();
    a_if.jump_valid = 1'b0;
    chk("mis_aligned_addr", a_if.rom_addr,       32'h40);
    chk("mis_sticky",       {31'b0, misalign_a}, 32'h1);

    // Async reset mid-stream while full
    a_if.inst_ready = 1'b0;
    tick();
    tick();
    chk("ar_count_pre", {28'b0, count_a}, 32'h2);
    #2;
    rst_a = 1'b0;
    #1;
    chk("ar_valid",    {31'b0, a_if.inst_valid}, 32'h0);
    chk("ar_count",    {28'b0, count_a},         32'h0);
    chk("ar_addr",     a_if.rom_addr,            32'h0);
    chk("ar_misalign", {31'b0, misalign_a},      32'h0);

    // Wrap-around instance and run toggling
    chk("wr_rst_addr", b_if.rom_addr, 32'hFFFF_FFFC);
    rst_b = 1'b1;
    tick();
    tick();
    chk("wr_pc0",   b_if.inst_pc,  32'hFFFF_FFFC);
    chk("wr_inst0", b_if.inst_out, 32'h0000_0003);
    chk("wr_addr",  b_if.rom_addr, 32'h0);
    tick();
    chk("wr_pc1",   b_if.inst_pc,  32'h0);
    chk("wr_inst1", b_if.inst_out, 32'h3401_1100);
    run = 1'b0;
    tick();
    chk("run_off_rom_ce", {31'b0, b_if.rom_ce}, 32'h0);
    chk("run_off_head",   b_if.inst_pc,         32'h4);
    chk("run_off_addr",   b_if.rom_addr,        32'h8);
    tick();
    chk("run_off_drained", {31'b0, b_if.inst_valid}, 32'h0);
    chk("run_off_count",   {28'b0, count_b},         32'h0);
    tick();
    chk("run_off_pc_hold", b_if.rom_addr,        32'h8);
    chk("run_off_ce_hold", {31'b0, b_if.rom_ce}, 32'h0);
    run = 1'b1;
    tick();
    chk("run_on_rom_ce", {31'b0, b_if.rom_ce}, 32'h1);
    chk("run_on_addr",   b_if.rom_addr,        32'h8);
    tick();
    chk("run_on_pc",   b_if.inst_pc,  32'h8);
    chk("run_on_inst", b_if.inst_out, 32'hFFFF_FFF7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
